// File: rtl/stats_pkg.sv
// Shared types, constants and helpers for the stats_scan_engine slice.
package stats_pkg;

   typedef enum logic [1:0] {IDLE, PRIME, SCAN, DONE} state_t;

   localparam int NO_MATCH_ID = -1;
   localparam int WIN_CNT_W   = 16;

   function automatic int id_w(input int n_windows);
      return $clog2(n_windows) + 1;
   endfunction

   function automatic int score_w(input int count_w, input int max_read, input int span_extra);
      return count_w + $clog2(max_read + span_extra);
   endfunction

   // Adds two unsigned values of width w (w <= 64) and clamps at 2^w-1.
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
      logic [64:0] sum;
      logic [64:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (65'd1 << w) - 65'd1;
      return (sum > lim) ? lim[63:0] : sum[63:0];
   endfunction

endpackage

// File: rtl/stats_scan_engine_if.sv
// Scan request/result handshake between the match controller and the engine.
// With STATS_TOP2_EN defined the runner-up result is carried as well.
interface stats_scan_engine_if #(
   parameter int ID_W    = 10,
   parameter int SCORE_W = 37
);
   logic                      calculate_matched_window;
   logic                      busy;
   logic                      done;
   logic                      match_valid;
   logic signed [ID_W-1:0]    matched_window_id;
   logic        [SCORE_W-1:0] matched_score;
`ifdef STATS_TOP2_EN
   logic signed [ID_W-1:0]    second_window_id;
   logic        [SCORE_W-1:0] second_score;

   modport master (output calculate_matched_window,
                   input  busy, done, match_valid, matched_window_id, matched_score,
                          second_window_id, second_score);
   modport slave  (input  calculate_matched_window,
                   output busy, done, match_valid, matched_window_id, matched_score,
                          second_window_id, second_score);
`else
   modport master (output calculate_matched_window,
                   input  busy, done, match_valid, matched_window_id, matched_score);
   modport slave  (input  calculate_matched_window,
                   output busy, done, match_valid, matched_window_id, matched_score);
`endif
endinterface

// File: rtl/stats_window_acc.sv
// Per-reference-window hit accumulators: commit on is_query falling edge,
// saturating add, blocking while a scan runs, and two read ports for the scanner.
module stats_window_acc
   import stats_pkg::*;
#(
   parameter int N       = 512,
   parameter int COUNT_W = 32,
   parameter int ADDR_W  = 10
) (
   input  logic                          clk,
   input  logic                          reset_stats_n,
   input  logic                          clear,
   input  logic                          is_query,
   input  logic [N-1:0][COUNT_W-1:0]     count_bus,
   input  logic                          block,
   input  logic [ADDR_W-1:0]             addr_a,
   input  logic [ADDR_W-1:0]             addr_b,
   output logic [COUNT_W-1:0]            rd_a,
   output logic [COUNT_W-1:0]            rd_b,
   output logic [WIN_CNT_W-1:0]          number_of_windows,
   output logic [WIN_CNT_W-1:0]          windows_next,
   output logic                          acc_dropped
);
   localparam int IW = $clog2(N);

   logic               prev_q;
   logic               commit;
   logic               apply;
   logic [COUNT_W-1:0] acc_q [N];

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_stats_n) prev_q <= 1'b0;
      else                prev_q <= is_query;
   end

   assign commit       = prev_q & ~is_query;
   assign apply        = commit & ~block & ~clear;
   assign windows_next = apply ? WIN_CNT_W'(sat_add(64'(number_of_windows), 64'd1, WIN_CNT_W))
                               : number_of_windows;

   // NOTE: the accumulators are a flop array, not a RAM, so clearing them in one cycle is legal.
   always_ff @(posedge clk) begin
      if (!reset_stats_n || clear) begin
         for (int i = 0; i < N; i++) acc_q[i] <= '0;
         number_of_windows <= '0;
         acc_dropped       <= 1'b0;
      end else begin
         if (apply) begin
            for (int i = 0; i < N; i++)
               acc_q[i] <= COUNT_W'(sat_add(64'(acc_q[i]), 64'(count_bus[i]), COUNT_W));
            number_of_windows <= windows_next;
         end
         if (commit && block) acc_dropped <= 1'b1;
      end
   end

   // Out-of-range addresses read as zero; the scanner relies on this for the last candidate.
   assign rd_a = (addr_a < ADDR_W'(N)) ? acc_q[addr_a[IW-1:0]] : '0;
   assign rd_b = (addr_b < ADDR_W'(N)) ? acc_q[addr_b[IW-1:0]] : '0;

endmodule

// File: rtl/stats_scan_engine.sv
// Per-read window statistics with a sliding-span best-window scan.
// Define STATS_TOP2_EN to also track the runner-up candidate.
module stats_scan_engine
   import stats_pkg::*;
#(
   parameter int MAX_WINDOWS_IN_REFERENCE = 512,
   parameter int MAX_WINDOWS_IN_READ      = 16,
   parameter int SPAN_EXTRA               = 3,
   parameter int COUNT_W                  = 32,
   parameter int MIN_SCORE                = 6
) (
   input  logic                                         clk,
   input  logic                                         reset_stats_n,
   input  logic                                         clear,
   input  logic                                         is_query,
   input  logic [MAX_WINDOWS_IN_REFERENCE-1:0][COUNT_W-1:0] count_bus,
   stats_scan_engine_if.slave                           scan,
   output logic [WIN_CNT_W-1:0]                         number_of_windows,
   output logic                                         acc_dropped
);
   localparam int N       = MAX_WINDOWS_IN_REFERENCE;
   localparam int ID_W    = id_w(N);
   localparam int SCORE_W = score_w(COUNT_W, MAX_WINDOWS_IN_READ, SPAN_EXTRA);
   localparam int CNT_W   = $clog2(N + MAX_WINDOWS_IN_READ + SPAN_EXTRA + 1);

   state_t                    state_q;
   logic [CNT_W-1:0]          idx_q, span_q, span_calc;
   logic [SCORE_W-1:0]        sum_q, score_q;
   logic signed [ID_W-1:0]    id_q;
   logic                      busy_q, done_q, valid_q;
   logic [COUNT_W-1:0]        rd_a, rd_b;
   logic [WIN_CNT_W-1:0]      windows_next;
`ifdef STATS_TOP2_EN
   logic [SCORE_W-1:0]        second_score_q;
   logic signed [ID_W-1:0]    second_id_q;
`endif

   stats_window_acc #(.N(N), .COUNT_W(COUNT_W), .ADDR_W(CNT_W)) u_acc (
      .clk, .reset_stats_n, .clear, .is_query, .count_bus,
      .block (state_q != IDLE),
      .addr_a(idx_q),
      .addr_b(idx_q + span_q),
      .rd_a, .rd_b, .number_of_windows, .windows_next, .acc_dropped
   );

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      span_calc = CNT_W'(windows_next);
      if (windows_next > WIN_CNT_W'(MAX_WINDOWS_IN_READ)) span_calc = CNT_W'(MAX_WINDOWS_IN_READ);
      span_calc = span_calc + CNT_W'(SPAN_EXTRA);
   end

   always_ff @(posedge clk) begin
      if (!reset_stats_n || clear) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         id_q    <= ID_W'(NO_MATCH_ID);
         score_q <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         span_q  <= '0;
`ifdef STATS_TOP2_EN
         second_id_q    <= ID_W'(NO_MATCH_ID);
         second_score_q <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: if (scan.calculate_matched_window) begin
               span_q  <= span_calc;
               sum_q   <= '0;
               idx_q   <= '0;
               valid_q <= 1'b0;
               id_q    <= ID_W'(NO_MATCH_ID);
               score_q <= '0;
`ifdef STATS_TOP2_EN
               second_id_q    <= ID_W'(NO_MATCH_ID);
               second_score_q <= '0;
`endif
               if (span_calc <= CNT_W'(N)) begin
                  state_q <= PRIME;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            PRIME: begin
               sum_q <= sum_q + SCORE_W'(rd_a);
               if (idx_q == span_q - 1'b1) begin
                  idx_q   <= '0;
                  state_q <= SCAN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            SCAN: begin
               if (sum_q >= SCORE_W'(MIN_SCORE)) begin
                  if (sum_q > score_q) begin
`ifdef STATS_TOP2_EN
                     second_id_q    <= id_q;
                     second_score_q <= score_q;
`endif
                     score_q <= sum_q;
                     id_q    <= ID_W'(idx_q);
                     valid_q <= 1'b1;
                  end
`ifdef STATS_TOP2_EN
                  else if (sum_q > second_score_q) begin
                     second_score_q <= sum_q;
                     second_id_q    <= ID_W'(idx_q);
                  end
`endif
               end
               sum_q <= sum_q - SCORE_W'(rd_a) + SCORE_W'(rd_b);
               if (idx_q == CNT_W'(N) - span_q) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign scan.busy              = busy_q;
   assign scan.done              = done_q;
   assign scan.match_valid       = valid_q;
   assign scan.matched_window_id = id_q;
   assign scan.matched_score     = score_q;
`ifdef STATS_TOP2_EN
   assign scan.second_window_id  = second_id_q;
   assign scan.second_score      = second_score_q;
`endif

endmodule
